// File: rtl/dffram_pkg.sv
// Shared DFFRAM port definitions: data/mask widths, write-mask constants and controller state encoding.
package dffram_pkg;

  localparam int DFFRAM_DW   = 32;
  localparam int DFFRAM_WE_W = 4;

  localparam logic [DFFRAM_WE_W-1:0] WE_ALL  = 4'hF;
  localparam logic [DFFRAM_WE_W-1:0] WE_READ = 4'h0;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } state_e;

  // A request with an all-zero byte mask is a read.
  function automatic logic is_read(input logic [DFFRAM_WE_W-1:0] we);
    return we == WE_READ;
  endfunction

endpackage

// File: rtl/dffram_rsp_fifo.sv
// Two-entry response FIFO: push/pop same cycle allowed, head visible combinationally, zero latency to head.
// No internal backpressure: the producer must not push when full unless popping in the same cycle.
module dffram_rsp_fifo
  import dffram_pkg::*;
#(
  parameter int DW = DFFRAM_DW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [DW-1:0] push_dat_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_dat_o,
  output logic          vld_o,
  output logic [1:0]    count_o
);

  logic [DW-1:0] mem_q [2];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    count_q;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; the count alone defines what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign vld_o      = (count_q != 2'd0);
  assign count_o    = count_q;

endmodule

// File: rtl/dffram_port_ctrl.sv
// DFFRAM initiator port: request stream to RAM cycles, in-order read data via a 2-entry FIFO, zero-fill on boot/command.
// Fire-to-rsp_valid is 2 cycles; req_ready is credit-gated on FIFO occupancy plus the in-flight read and held low while filling.
module dffram_port_ctrl
  import dffram_pkg::*;
#(
  parameter int A_WIDTH       = 9,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   init_start,
  output logic                   init_busy,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [DFFRAM_WE_W-1:0] req_we,
  input  logic [A_WIDTH-1:0]     req_addr,
  input  logic [DFFRAM_DW-1:0]   req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DFFRAM_DW-1:0]   rsp_rdata,
  output logic                   ram_EN0,
  output logic [DFFRAM_WE_W-1:0] ram_WE0,
  output logic [A_WIDTH-1:0]     ram_A0,
  output logic [DFFRAM_DW-1:0]   ram_Di0,
  input  logic [DFFRAM_DW-1:0]   ram_Do0
);

  localparam logic [A_WIDTH-1:0] CNT_LAST = '1;
  localparam logic [A_WIDTH-1:0] CNT_ONE  = A_WIDTH'(1);

  state_e             state_q, state_d;
  logic [A_WIDTH-1:0] cnt_q, cnt_d;
  logic               inflight_q, inflight_d;
  logic               init_pend_q, init_pend_d;

  logic               run_rdy;
  logic               fire;
  logic               fifo_pop;
  logic               fifo_vld;
  logic [1:0]         fifo_cnt;
  logic [2:0]         occ;

  // A read still inside the RAM already owns a FIFO slot.
  assign occ       = {1'b0, fifo_cnt} + {2'b00, inflight_q};
  assign run_rdy   = (state_q == RUN) && !init_pend_q && (occ < 3'd2);
  assign req_ready = run_rdy;
  assign fire      = req_valid && run_rdy;
  assign fifo_pop  = fifo_vld && rsp_ready;
  assign rsp_valid = fifo_vld;
  assign init_busy = init_pend_q || (state_q == INIT) || ((state_q == BOOT) && INIT_ON_RESET);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_pend_d = init_pend_q;
    inflight_d  = 1'b0;
    ram_EN0     = 1'b0;
    ram_WE0     = WE_READ;
    ram_A0      = '0;
    ram_Di0     = '0;
    unique case (state_q)
      BOOT: begin
        state_d = INIT_ON_RESET ? INIT : RUN;
      end
      INIT: begin
        ram_EN0 = 1'b1;
        ram_WE0 = WE_ALL;
        ram_A0  = cnt_q;
        cnt_d   = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (fire) begin
          ram_EN0    = 1'b1;
          ram_WE0    = req_we;
          ram_A0     = req_addr;
          ram_Di0    = req_wdata;
          inflight_d = is_read(req_we);
        end
        if (init_start) begin
          init_pend_d = 1'b1;
        end
        // Start the fill only once every accepted read has been handed off.
        if (init_pend_q && !fifo_vld && !inflight_q) begin
          state_d     = INIT;
          init_pend_d = 1'b0;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= BOOT;
      cnt_q       <= '0;
      inflight_q  <= 1'b0;
      init_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      inflight_q  <= inflight_d;
      init_pend_q <= init_pend_d;
    end
  end

  dffram_rsp_fifo #(
    .DW(DFFRAM_DW)
  ) u_rsp_fifo (
    .clk_i      (CLK),
    .rst_i      (RST),
    .push_i     (inflight_q),
    .push_dat_i (ram_Do0),
    .pop_i      (fifo_pop),
    .head_dat_o (rsp_rdata),
    .vld_o      (fifo_vld),
    .count_o    (fifo_cnt)
  );

endmodule

// File: tb/tb_dffram_port_ctrl.sv
// Bench for dffram_port_ctrl: RAM stand-in plus a word-level reference memory and expected-response queue.
module tb_dffram_port_ctrl;

  localparam int AW    = 9;
  localparam int DEPTH = 512;

  logic          CLK = 1'b0;
  logic          RST;
  logic          init_start;
  logic          init_busy;
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_we;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          ram_EN0;
  logic [3:0]    ram_WE0;
  logic [AW-1:0] ram_A0;
  logic [31:0]   ram_Di0;
  logic [31:0]   ram_Do0;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] ram_mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_q [$];
  bit          run_mode;
  bit          pend_model;
  logic [31:0] last_rsp;
  int          npops;

  always #5 CLK = ~CLK;

  dffram_port_ctrl #(.A_WIDTH(AW), .INIT_ON_RESET(1'b1)) dut (
    .CLK(CLK), .RST(RST), .init_start(init_start), .init_busy(init_busy),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .ram_EN0(ram_EN0), .ram_WE0(ram_WE0), .ram_A0(ram_A0),
    .ram_Di0(ram_Di0), .ram_Do0(ram_Do0)
  );

  // Single-port RAM: byte-masked write, 1-cycle read, output zero when idle.
  always @(posedge CLK) begin
    if (ram_EN0) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_WE0[b]) ram_mem[ram_A0][8*b +: 8] <= ram_Di0[8*b +: 8];
      end
      ram_Do0 <= (ram_WE0 == 4'h0) ? ram_mem[ram_A0] : 32'h0;
    end else begin
      ram_Do0 <= 32'h0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] we);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic chk_reset(input string p);
    chk({p, "_rsp_valid"}, rsp_valid, 0);
    chk({p, "_req_ready"}, req_ready, 0);
    chk({p, "_en0"}, ram_EN0, 0);
    chk({p, "_we0"}, ram_WE0, 0);
    chk({p, "_a0"}, ram_A0, 0);
    chk({p, "_di0"}, ram_Di0, 0);
    chk({p, "_init_busy"}, init_busy, 1);
  endtask

  // One clock: drive at the falling edge, evaluate the handshake 1 ns later.
  task automatic step(input logic v, input logic [3:0] we, input logic [AW-1:0] a,
                      input logic [31:0] d, input logic rr, input logic ist, output logic fired);
    @(negedge CLK);
    req_valid = v; req_we = we; req_addr = a; req_wdata = d; rsp_ready = rr; init_start = ist;
    #1;
    if (run_mode) chk("req_ready", req_ready, !pend_model && (exp_q.size() < 2));
    fired = v && req_ready;
    if (rsp_valid && rr) begin
      npops++;
      last_rsp = rsp_rdata;
      if (exp_q.size() == 0) chk("rsp_spurious", rsp_valid, 0);
      else chk("rsp_rdata", rsp_rdata, exp_q.pop_front());
    end
    if (run_mode) chk("ram_en", ram_EN0, fired);
    if (fired) begin
      chk("ram_a0", ram_A0, a);
      chk("ram_we", ram_WE0, we);
      if (we == 4'h0) exp_q.push_back(ref_mem[a]);
      else ref_mem[a] = merge(ref_mem[a], d, we);
    end
    if (ist && run_mode) pend_model = 1'b1;
  endtask

  task automatic drain(input string tag);
    logic f;
    int guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      step(1'b0, 4'h0, '0, 32'h0, 1'b1, 1'b0, f);
      guard++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  // Finds the first filling cycle, then checks ncyc consecutive fill cycles from address 0.
  task automatic wait_fill(input string tag, input int ncyc, output int lead);
    int good = 0;
    lead = 0;
    req_valid = 1'b0; init_start = 1'b0; rsp_ready = 1'b1;
    run_mode = 1'b0; pend_model = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge CLK); #1;
      if (ram_EN0) break;
      lead++;
    end
    for (int i = 0; i < ncyc; i++) begin
      if (i > 0) begin @(negedge CLK); #1; end
      if (ram_EN0 === 1'b1 && ram_WE0 === 4'hF && ram_A0 === i[AW-1:0] &&
          ram_Di0 === 32'h0 && req_ready === 1'b0 && init_busy === 1'b1) good++;
    end
    chk(tag, good, ncyc);
    if (ncyc == DEPTH) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
      run_mode = 1'b1;
    end
  endtask

  initial begin
    logic          f;
    int            lead, idx, acc, p0;
    logic [AW-1:0] ad;
    logic [3:0]    rw;

    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i] = $urandom;
      ref_mem[i] = 32'h0;
    end
    RST = 1'b1; init_start = 1'b0; req_valid = 1'b0; req_we = 4'h0;
    req_addr = '0; req_wdata = 32'h0; rsp_ready = 1'b0;
    run_mode = 1'b0; pend_model = 1'b0; npops = 0; last_rsp = 32'h0;

    // Reset values, one BOOT cycle, then the full fill.
    repeat (3) @(negedge CLK);
    #1;
    chk_reset("rst");
    RST = 1'b0;
    #1;
    chk("boot_en0", ram_EN0, 0);
    chk("boot_busy", init_busy, 1);
    wait_fill("fill1", DEPTH, lead);
    chk("fill1_lead", lead, 0);
    step(1'b1, 4'h0, 9'h1FF, 32'h0, 1'b1, 1'b0, f);
    chk("t1_fire", f, 1);
    drain("t1_drain");
    chk("t1_data", last_rsp, 32'h0);

    // Read-after-write and 2-cycle latency.
    step(1'b1, 4'hF, 9'h1A5, 32'hDEADBEEF, 1'b1, 1'b0, f);
    step(1'b1, 4'h0, 9'h1A5, 32'h0, 1'b1, 1'b0, f);
    chk("t2_fire", f, 1);
    step(1'b0, 4'h0, '0, 32'h0, 1'b1, 1'b0, f);
    chk("t2_lat1", rsp_valid, 0);
    step(1'b0, 4'h0, '0, 32'h0, 1'b1, 1'b0, f);
    chk("t2_lat2", rsp_valid, 1);
    chk("t2_data", last_rsp, 32'hDEADBEEF);

    // Byte-masked write.
    step(1'b1, 4'hF, 9'h010, 32'h11223344, 1'b1, 1'b0, f);
    step(1'b1, 4'b0101, 9'h010, 32'hAABBCCDD, 1'b1, 1'b0, f);
    step(1'b1, 4'h0, 9'h010, 32'h0, 1'b1, 1'b0, f);
    drain("t3_drain");
    chk("t3_data", last_rsp, 32'h11BB33DD);

    // Backpressure: only two reads accepted, then all four return in order.
    for (int i = 0; i < 4; i++) begin
      ad = 9'h020 + AW'(i);
      step(1'b1, 4'hF, ad, $urandom, 1'b1, 1'b0, f);
    end
    idx = 0; acc = 0;
    for (int c = 0; c < 4; c++) begin
      ad = 9'h020 + AW'(idx);
      step(1'b1, 4'h0, ad, 32'h0, 1'b0, 1'b0, f);
      if (f) begin idx++; acc++; end
    end
    chk("t4_accept", acc, 2);
    chk("t4_ready", req_ready, 0);
    p0 = npops - 0;
    for (int c = 0; c < 20 && (idx < 4 || exp_q.size() != 0); c++) begin
      ad = 9'h020 + AW'(idx);
      step(idx < 4, 4'h0, ad, 32'h0, 1'b1, 1'b0, f);
      if (f) idx++;
    end
    chk("t4_pops", npops - p0, 4);

    // init_start with two responses queued.
    step(1'b1, 4'h0, 9'h1A5, 32'h0, 1'b0, 1'b0, f);
    step(1'b1, 4'h0, 9'h010, 32'h0, 1'b0, 1'b0, f);
    step(1'b0, 4'h0, '0, 32'h0, 1'b0, 1'b1, f);
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 4'hF, 9'h030, 32'h12345678, 1'b0, 1'b0, f);
      chk("t5_busy", init_busy, 1);
      chk("t5_blocked", f, 0);
    end
    p0 = npops;
    step(1'b0, 4'h0, '0, 32'h0, 1'b1, 1'b0, f);
    step(1'b0, 4'h0, '0, 32'h0, 1'b1, 1'b0, f);
    chk("t5_pops", npops - p0, 2);
    wait_fill("fill2", DEPTH, lead);
    chk("t5_lead", lead, 1);
    step(1'b1, 4'h0, 9'h1A5, 32'h0, 1'b1, 1'b0, f);
    step(1'b1, 4'h0, 9'h010, 32'h0, 1'b1, 1'b0, f);
    step(1'b1, 4'h0, 9'h021, 32'h0, 1'b1, 1'b0, f);
    drain("t5_drain");
    chk("t5_zero", last_rsp, 32'h0);

    // Random traffic over a small address window to hit read-after-write often.
    for (int c = 0; c < 400; c++) begin
      rw = ($urandom_range(1, 0) == 0) ? 4'h0 : 4'($urandom_range(15, 0));
      ad = AW'($urandom_range(15, 0));
      step($urandom_range(3, 0) != 0, rw, ad, $urandom, $urandom_range(3, 0) != 0, 1'b0, f);
    end
    drain("rnd_drain");

    // Reset with responses queued, then reset again mid-fill.
    step(1'b1, 4'h0, 9'h003, 32'h0, 1'b0, 1'b0, f);
    step(1'b1, 4'h0, 9'h004, 32'h0, 1'b0, 1'b0, f);
    RST = 1'b1;
    exp_q.delete();
    run_mode = 1'b0;
    @(negedge CLK); #1;
    chk_reset("t6a");
    RST = 1'b0;
    wait_fill("fill3_part", 200, lead);
    @(negedge CLK); #1;
    chk("t6_a200", ram_A0, 200);
    RST = 1'b1;
    #1;
    chk_reset("t6b");
    @(negedge CLK); #1;
    RST = 1'b0;
    #1;
    chk("t6_boot_en0", ram_EN0, 0);
    wait_fill("fill4", DEPTH, lead);
    chk("fill4_lead", lead, 0);
    step(1'b1, 4'h0, 9'h1FF, 32'h0, 1'b1, 1'b0, f);
    step(1'b1, 4'h0, 9'h005, 32'h0, 1'b1, 1'b0, f);
    drain("t6_drain");
    chk("t6_zero", last_rsp, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
